// File: rtl/ev_counter_ctrl.sv
// ev_counter_ctrl: command-driven sequencer for the ev_counter datapath.
// Holds the start, terminal, prescale and direction settings. Loads the counter,
// paces its count-enable strobe, detects the terminal value and pulses done.
// Optional feature: define EV_CTRL_AUTORELOAD_EN for periodic auto-reload.
//
// Command handshake: a command is taken on a rising edge where
// cmd_valid && cmd_ready. cmd_ready is low only in LOAD, so a source must hold
// cmd_valid, cmd_op and cmd_data steady until the command is taken.
module ev_counter_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [WIDTH-1:0]    cmd_data,
  input  logic [WIDTH-1:0]    cnt_value,
  output logic                cnt_en,
  output logic                cnt_dir,
  output logic                cnt_load,
  output logic [WIDTH-1:0]    cnt_load_val,
  output logic                done,
  output logic                busy,
  output logic [1:0]          state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  // Opcode 0 is NOP: it is accepted and does nothing, so it needs no decode.
  localparam logic [2:0] OP_SET_START   = 3'd1;
  localparam logic [2:0] OP_SET_TERM    = 3'd2;
  localparam logic [2:0] OP_SET_PRESC   = 3'd3;
  localparam logic [2:0] OP_SET_DIR     = 3'd4;
  localparam logic [2:0] OP_START       = 3'd5;
  localparam logic [2:0] OP_STOP        = 3'd6;
  localparam logic [2:0] OP_ABORT       = 3'd7;

  localparam logic [PRESCALE_W-1:0] PC_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_next_state;
  logic [WIDTH-1:0]      r_start;
  logic [WIDTH-1:0]      r_term;
  logic [PRESCALE_W-1:0] r_presc;
  logic [PRESCALE_W-1:0] r_presc_cnt;
  logic                  r_dir;
`ifdef EV_CTRL_AUTORELOAD_EN
  logic                  r_reload;
`endif

  logic w_accept;
  logic w_op_start;
  logic w_op_stop;
  logic w_op_abort;
  logic w_hit;
  logic w_step;
  logic w_done;

  assign cmd_ready  = (r_state != ST_LOAD);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_op_start = w_accept && (cmd_op == OP_START);
  assign w_op_stop  = w_accept && (cmd_op == OP_STOP);
  assign w_op_abort = w_accept && (cmd_op == OP_ABORT);

  // Terminal compare takes priority over stepping in RUN.
  assign w_hit  = (r_state == ST_RUN) && (cnt_value == r_term);
  assign w_step = (r_state == ST_RUN) && !w_hit && (r_presc_cnt == r_presc);

  assign cnt_en       = w_step;
  assign cnt_load     = (r_state == ST_LOAD);
  assign busy         = (r_state != ST_IDLE);
  assign state        = r_state;
  assign cnt_dir      = r_dir;
  assign cnt_load_val = r_start;
  assign done         = w_done;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and done pulse; ABORT beats a terminal hit, a hit beats STOP.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_op_start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (w_op_abort) begin
          w_next_state = ST_IDLE;
        end else if (w_hit) begin
          w_done = 1'b1;
`ifdef EV_CTRL_AUTORELOAD_EN
          w_next_state = r_reload ? ST_LOAD : ST_IDLE;
`else
          w_next_state = ST_IDLE;
`endif
        end else if (w_op_stop) begin
          w_next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (w_op_abort)      w_next_state = ST_IDLE;
        else if (w_op_start) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Prescale counter: cleared in LOAD, wraps at presc_reg in RUN, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc_cnt <= '0;
    end else if (r_state == ST_LOAD) begin
      r_presc_cnt <= '0;
    end else if ((r_state == ST_RUN) && !w_hit) begin
      if (w_step) r_presc_cnt <= '0;
      else        r_presc_cnt <= r_presc_cnt + PC_ONE;
    end
  end

  // Configuration registers; direction (and reload) only change while IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start  <= '0;
      r_term   <= '1;
      r_presc  <= '0;
      r_dir    <= 1'b1;
`ifdef EV_CTRL_AUTORELOAD_EN
      r_reload <= 1'b0;
`endif
    end else if (w_accept) begin
      case (cmd_op)
        OP_SET_START: r_start <= cmd_data;
        OP_SET_TERM:  r_term  <= cmd_data;
        OP_SET_PRESC: r_presc <= cmd_data[PRESCALE_W-1:0];
        OP_SET_DIR: begin
          if (r_state == ST_IDLE) begin
            r_dir    <= cmd_data[0];
`ifdef EV_CTRL_AUTORELOAD_EN
            r_reload <= cmd_data[1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ev_counter_ctrl.sv
// tb_ev_counter_ctrl: directed and randomized checks of ev_counter_ctrl with a
// behavioural counter register attached to the cnt_* port. Expected timing is
// derived from the stepping rule: with prescale P and k steps to the terminal,
// done appears at RUN cycle k*(P+1), counting the first RUN cycle as 0.
module tb_ev_counter_ctrl;
  localparam int W = 8;

  localparam logic [2:0] C_NOP = 3'd0, C_SSTART = 3'd1, C_STERM = 3'd2,
                         C_SPRESC = 3'd3, C_SDIR = 3'd4, C_START = 3'd5,
                         C_STOP = 3'd6, C_ABORT = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_data = '0;
  logic [W-1:0] cnt_value;
  logic         cnt_en, cnt_dir, cnt_load, done, busy;
  logic [W-1:0] cnt_load_val;
  logic [1:0]   state;

  int n_pass  = 0;
  int n_total = 0;
  logic [W-1:0] exp_q[$];

  ev_counter_ctrl #(.WIDTH(W), .PRESCALE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cnt_value(cnt_value),
    .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_load(cnt_load),
    .cnt_load_val(cnt_load_val), .done(done), .busy(busy), .state(state)
  );

  // Clock and the counter register the sequencer drives.
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_value <= '0;
    else if (cnt_load) cnt_value <= cnt_load_val;
    else if (cnt_en)   cnt_value <= cnt_dir ? cnt_value + 8'd1 : cnt_value - 8'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [W-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
  endtask

  task automatic release_cmd();
    cmd_valid = 1'b0;
    cmd_op    = C_NOP;
    cmd_data  = '0;
  endtask

  // Present a command, wait (bounded) for cmd_ready, return just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] data);
    int n = 0;
    drive(op, data);
    #1;
    while (cmd_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk("cmd_accept", (n < 8), 1);
    tick();
    release_cmd();
  endtask

  task automatic cfg(input logic [W-1:0] s, input logic [W-1:0] t,
                     input logic [W-1:0] p, input logic [W-1:0] d);
    send(C_SSTART, s);
    send(C_STERM, t);
    send(C_SPRESC, p);
    send(C_SDIR, d);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_en"}, cnt_en, 0);
    chk({tag, "_load"}, cnt_load, 0);
    chk({tag, "_loadval"}, cnt_load_val, 0);
    chk({tag, "_dir"}, cnt_dir, 1);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called in RUN cycle 0; waits (bounded) for done and checks timing/step count.
  task automatic measure(input string tag, input int exp_idx, input int exp_steps,
                         input logic [W-1:0] exp_term);
    int idx = 0;
    int en = 0;
    while (done !== 1'b1 && idx < 600) begin
      if (cnt_en === 1'b1) en++;
      tick();
      idx++;
    end
    chk({tag, "_done_cycle"}, idx, exp_idx);
    chk({tag, "_steps"}, en, exp_steps);
    chk({tag, "_value"}, cnt_value, exp_term);
    chk({tag, "_en_at_done"}, cnt_en, 0);
    tick();
    chk({tag, "_idle_after"}, state, 0);
  endtask

  // Run to the terminal RUN cycle (value 2 from 0, P=0) and collide a command with it.
  task automatic collide(input string tag, input logic [2:0] op, input logic exp_done);
    cfg(8'd0, 8'd2, 8'd0, 8'd1);
    send(C_START, 8'd0);
    tick();
    tick();
    tick();
    drive(op, 8'd0);
    #1;
    chk({tag, "_value"}, cnt_value, 2);
    chk({tag, "_done"}, done, exp_done);
    tick();
    release_cmd();
    chk({tag, "_state"}, state, 0);
    tick();
    chk({tag, "_state_hold"}, state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int en;
    int bad;
    int s, k, p, d;
    logic [W-1:0] t;
    logic [W-1:0] v;
    int done_t[$];

    // Reset.
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    #3 rst_n = 1'b1;
    tick();

    // Basic run with START held through LOAD.
    cfg(8'd3, 8'd6, 8'd0, 8'd1);
    drive(C_START, 8'd0);
    tick();
    chk("load_strobe", cnt_load, 1);
    chk("load_val", cnt_load_val, 3);
    chk("load_ready", cmd_ready, 0);
    chk("load_state", state, 1);
    tick();
    release_cmd();
    chk("run_after_load", state, 2);
    chk("run_busy", busy, 1);
    measure("basic", 3, 3, 8'd6);

    // Prescale and pause: P=2, 0 -> 4.
    cfg(8'd0, 8'd4, 8'd2, 8'd1);
    send(C_START, 8'd0);
    tick();
    cyc = 0;
    en = 0;
    while (cyc < 50) begin
      if (cnt_en === 1'b1) begin
        en++;
        if (en == 2) break;
      end
      tick();
      cyc++;
    end
    chk("presc_2nd_step_cycle", cyc, 2 * 3 - 1);
    tick();
    drive(C_STOP, 8'd0);
    tick();
    release_cmd();
    chk("pause_state", state, 3);
    bad = 0;
    repeat (10) begin
      if (cnt_en !== 1'b0 || state !== 2'd3) bad++;
      tick();
    end
    chk("pause_hold", bad, 0);
    chk("pause_value", cnt_value, 2);
    drive(C_START, 8'd0);
    tick();
    release_cmd();
    chk("resume_state", state, 2);
    // 7 RUN cycles elapsed before the pause; done lands at total RUN cycle 4*3.
    measure("resume", 4 * 3 - 7, 2, 8'd4);

    // Collisions on the terminal cycle.
    collide("stop_hit", C_STOP, 1'b1);
    collide("abort_hit", C_ABORT, 1'b0);

    // start == term: zero steps, done in first RUN cycle.
    cfg(8'd9, 8'd9, 8'd0, 8'd1);
    send(C_START, 8'd0);
    tick();
    measure("start_eq_term", 0, 0, 8'd9);

    // Down-count through wrap: 0 -> 0xFF -> 0xFE.
    cfg(8'd0, 8'hFE, 8'd0, 8'd0);
    send(C_START, 8'd0);
    tick();
    measure("down_wrap", 2, 2, 8'hFE);

    // SET_DIR in RUN is dropped; SET_TERM in RUN applies next cycle.
    cfg(8'd0, 8'h80, 8'd0, 8'd1);
    send(C_START, 8'd0);
    tick();
    send(C_SDIR, 8'd0);
    chk("setdir_run_dir", cnt_dir, 1);
    chk("setdir_run_state", state, 2);
    v = cnt_value;
    send(C_STERM, v + 8'd2);
    measure("term_change", 1, 1, v + 8'd2);

    // Randomized runs against the stepping rule.
    for (int i = 0; i < 8; i++) begin
      s = $urandom_range(0, 255);
      k = $urandom_range(0, 12);
      p = $urandom_range(0, 3);
      d = $urandom_range(0, 1);
      t = d ? W'(s + k) : W'(s - k);
      exp_q.push_back(t);
`ifdef EV_CTRL_AUTORELOAD_EN
      cfg(W'(s), t, W'(p), W'(d));
`else
      cfg(W'(s), t, W'(p), W'(d + 2 * $urandom_range(0, 1)));
`endif
      send(C_START, 8'd0);
      chk("rnd_load_val", cnt_load_val, s);
      tick();
      measure("rnd", k * (p + 1), k, exp_q.pop_front());
    end

    // Asynchronous reset mid-RUN.
    cfg(8'd5, 8'h50, 8'd0, 8'd0);
    send(C_START, 8'd0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk_reset("midrun_reset");
    #3 rst_n = 1'b1;
    tick();
    send(C_START, 8'd0);
    chk("post_reset_loadval", cnt_load_val, 0);
    tick();
    measure("post_reset_term", 255, 255, 8'hFF);

`ifdef EV_CTRL_AUTORELOAD_EN
    // Periodic operation: LOAD + 3 RUN cycles per done.
    cfg(8'd1, 8'd3, 8'd0, 8'd3);
    send(C_START, 8'd0);
    tick();
    for (int c = 0; c < 20; c++) begin
      if (done === 1'b1) done_t.push_back(c);
      tick();
    end
    chk("reload_count", done_t.size(), 5);
    if (done_t.size() > 0) chk("reload_first", done_t[0], 2);
    for (int j = 1; j < done_t.size(); j++) chk("reload_gap", done_t[j] - done_t[j-1], 4);
    send(C_ABORT, 8'd0);
    chk("reload_abort", state, 0);
    tick();
    chk("reload_abort_hold", state, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
